// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory subsystem.
//   MEM_ADDR_W / MEM_DATA_W : default memory address and word widths
//   arb_state_e             : mem_port_arbiter FSM states (IDLE, ISSUE, RESP)
//   req_id_e                : requester identifiers (REQ_CPU, REQ_DBG)
package cpu_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port program/data memory between the
// CPU state machine and the debug/loader port. One access in flight at a time.
//
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : ties alternate using a last-grant flag (CPU wins first tie)
//   undefined : fixed priority, CPU wins every tie
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req/we/addr/wdata  (in)      CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata   CPU grant pulse, read-valid pulse, data
//   dbg_*                            same set for the debug/loader requester
//   dbg_lock               (in)      blocks CPU grants while high
//   mem_en/we/addr/wdata   (out)     memory access strobe and fields
//   mem_rdata              (in)      memory data, valid cycle after mem_en
//   busy                   (out)     FSM not in IDLE
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::MEM_ADDR_W,
  parameter int DATA_W = cpu_pkg::MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  req_id_e           sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic cpu_gnt_q, cpu_gnt_d;
  logic dbg_gnt_q, dbg_gnt_d;
  logic cpu_rvalid_q, cpu_rvalid_d;
  logic dbg_rvalid_q, dbg_rvalid_d;
  logic mem_en_q, mem_en_d;
  logic mem_we_q, mem_we_d;
  logic busy_q, busy_d;

  logic cpu_elig;
  logic dbg_elig;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e last_q, last_d;

  function automatic req_id_e pick(input logic cpu_el, input logic dbg_el,
                                   input req_id_e last);
    if (cpu_el && dbg_el) begin
      pick = (last == REQ_DBG) ? REQ_CPU : REQ_DBG;
    end else if (dbg_el) begin
      pick = REQ_DBG;
    end else begin
      pick = REQ_CPU;
    end
  endfunction
`else
  function automatic req_id_e pick(input logic cpu_el, input logic dbg_el);
    if (cpu_el || !dbg_el) begin
      pick = REQ_CPU;
    end else begin
      pick = REQ_DBG;
    end
  endfunction
`endif

  assign cpu_elig = cpu_req & ~dbg_lock;
  assign dbg_elig = dbg_req;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif

    unique case (state_q)
      ARB_IDLE: begin
        if (cpu_elig || dbg_elig) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          sel_d  = pick(cpu_elig, dbg_elig, last_q);
          last_d = sel_d;
`else
          sel_d  = pick(cpu_elig, dbg_elig);
`endif
          if (sel_d == REQ_DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = we_q ? ARB_IDLE : ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase

    // Output strobes are decoded from the next state so they come straight
    // out of flops in the cycle the FSM occupies ISSUE / RESP.
    mem_en_d     = (state_d == ARB_ISSUE);
    mem_we_d     = (state_d == ARB_ISSUE) && we_d;
    cpu_gnt_d    = (state_d == ARB_ISSUE) && (sel_d == REQ_CPU);
    dbg_gnt_d    = (state_d == ARB_ISSUE) && (sel_d == REQ_DBG);
    cpu_rvalid_d = (state_d == ARB_RESP) && (sel_d == REQ_CPU);
    dbg_rvalid_d = (state_d == ARB_RESP) && (sel_d == REQ_DBG);
    busy_d       = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      sel_q        <= REQ_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q       <= REQ_DBG;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;

  // Only the path from memory data is combinational, and only in RESP.
  assign cpu_rdata = (state_q == ARB_RESP && sel_q == REQ_CPU) ? mem_rdata : '0;
  assign dbg_rdata = (state_q == ARB_RESP && sel_q == REQ_DBG) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, contention and lock
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Power-on memory contents, shared by the memory and the reference model.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 12'h01F) return 16'h3A42;
    return {a[3:0], a} ^ 16'hC3A5;
  endfunction

  // Synchronous single-port memory: data one cycle after the mem_en cycle.
  logic [DW-1:0] ram [4096];
  bit            ram_wr [4096];
  logic [DW-1:0] ram_rdata;
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        ram_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
      end
    end
  end
  assign mem_rdata = ram_rdata;

  // ---------------- transaction-level reference model ----------------
  // age = cycles since the access was granted (0 = no access in flight).
  // A read occupies 3 cycles, a write 2; gnt shows at age 1, rvalid at age 2.
  bit            rr_mode;
  int            age = 0;
  int            len = 0;
  bit            m_dbg = 1'b0;
  bit            m_we = 1'b0;
  bit            m_rst = 1'b0;
  bit            last_dbg = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] sh [4096];
  bit            sh_wr [4096];

  task automatic model_update();
    bit ce, de, win;
    if (rst) begin
      age = 0; last_dbg = 1'b1; m_rst = 1'b1; m_addr = '0; m_wdata = '0;
    end else begin
      m_rst = 1'b0;
      if (age != 0) begin
        age++;
        if (age == len) age = 0;
      end else begin
        ce = cpu_req && !dbg_lock;
        de = dbg_req;
        if (ce || de) begin
          if (ce && de) win = rr_mode ? !last_dbg : 1'b0;
          else          win = de;
          last_dbg = win;
          m_dbg    = win;
          m_we     = win ? dbg_we : cpu_we;
          m_addr   = win ? dbg_addr : cpu_addr;
          m_wdata  = win ? dbg_wdata : cpu_wdata;
          len      = m_we ? 2 : 3;
          age      = 1;
          if (m_we) begin
            sh[m_addr] = m_wdata; sh_wr[m_addr] = 1'b1;
          end else begin
            m_rdata = sh_wr[m_addr] ? sh[m_addr] : init_val(m_addr);
          end
        end
      end
    end
  endtask

  function automatic logic [66:0] pack_act();
    return {cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy,
            mem_addr, mem_wdata, cpu_rdata, dbg_rdata};
  endfunction

  function automatic logic [66:0] mk_mask(input bit ca, input bit cw, input bit cr);
    return {7'h7F, ca ? 12'hFFF : 12'h000, cw ? 16'hFFFF : 16'h0000,
            cr ? 32'hFFFF_FFFF : 32'h0};
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int cyc = 0;
  task automatic step();
    bit iss, resp;
    logic [66:0] e, m;
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    iss  = (age == 1);
    resp = (age == 2) && !m_we;
    e = {iss && !m_dbg, resp && !m_dbg, iss && m_dbg, resp && m_dbg, iss, iss && m_we,
         age != 0, m_addr, m_wdata,
         (resp && !m_dbg) ? m_rdata : 16'h0, (resp && m_dbg) ? m_rdata : 16'h0};
    m = mk_mask(iss || m_rst, (iss && m_we) || m_rst, resp || m_rst);
    chk($sformatf("model cyc%0d", cyc), pack_act() & m, e & m);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst;
    logic creq, cwe; logic [AW-1:0] caddr; logic [DW-1:0] cwd;
    logic dreq, dwe; logic [AW-1:0] daddr; logic [DW-1:0] dwd;
    logic lock;
    logic e_cg, e_crv; logic [DW-1:0] e_crd;
    logic e_dg, e_drv; logic [DW-1:0] e_drd;
    logic e_en, e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_wd;
    logic e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic cq, input logic cw, input logic [AW-1:0] ca,
    input logic [DW-1:0] cd, input logic dq, input logic dw, input logic [AW-1:0] da,
    input logic [DW-1:0] dd, input logic lk, input logic ecg, input logic ecrv,
    input logic [DW-1:0] ecrd, input logic edg, input logic edrv, input logic [DW-1:0] edrd,
    input logic een, input logic ewe, input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
    input logic eb);
    vec_t v;
    v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
    v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwd = dd; v.lock = lk;
    v.e_cg = ecg; v.e_crv = ecrv; v.e_crd = ecrd; v.e_dg = edg; v.e_drv = edrv;
    v.e_drd = edrd; v.e_en = een; v.e_we = ewe; v.e_addr = ea; v.e_wd = ewd; v.e_busy = eb;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd; dbg_lock = v.lock;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 1'b0;
  endtask

  vec_t vt [17];
  logic [1:0] gq [$];

  initial begin
    int n_cg, n_drv, lat;
    bit d_seen, c_done, d_done, found;
    logic [66:0] e, m;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    idle_inputs();
    rst = 1'b1;

    // Each row: inputs held for one cycle, outputs checked after the edge.
    //            rst cq cw caddr  cwd  dq dw daddr  dwd      lk cg crv crd     dg drv drd en we addr   wd       busy
    vt[0]  = mk(1, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 12'h000, 16'h0,    0);
    vt[1]  = mk(0, 1, 0, 12'h01F, 0, 0, 0, 12'h000, 0,       0, 1, 0, 16'h0,    0, 0, 0, 1, 0, 12'h01F, 16'h0,    1);
    vt[2]  = mk(0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 1, 16'h3A42, 0, 0, 0, 0, 0, 12'h000, 16'h0,    1);
    vt[3]  = mk(0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 12'h000, 16'h0,    0);
    vt[4]  = mk(0, 0, 0, 12'h000, 0, 1, 1, 12'h100, 16'hA5A5, 0, 0, 0, 16'h0,   1, 0, 0, 1, 1, 12'h100, 16'hA5A5, 1);
    vt[5]  = mk(0, 1, 0, 12'h100, 0, 0, 0, 12'h000, 0,       0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 12'h000, 16'h0,    0);
    vt[6]  = mk(0, 1, 0, 12'h100, 0, 0, 0, 12'h000, 0,       0, 1, 0, 16'h0,    0, 0, 0, 1, 0, 12'h100, 16'h0,    1);
    vt[7]  = mk(0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 1, 16'hA5A5, 0, 0, 0, 0, 0, 12'h000, 16'h0,    1);
    vt[8]  = mk(0, 1, 0, 12'h01F, 0, 0, 0, 12'h000, 0,       0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 12'h000, 16'h0,    0);
    vt[9]  = mk(0, 1, 0, 12'h01F, 0, 0, 0, 12'h000, 0,       0, 1, 0, 16'h0,    0, 0, 0, 1, 0, 12'h01F, 16'h0,    1);
    vt[10] = mk(0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 1, 16'h3A42, 0, 0, 0, 0, 0, 12'h000, 16'h0,    1);
    // reset held during RESP, then during ISSUE: access aborted, outputs zero
    vt[11] = mk(1, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 12'h000, 16'h0,    0);
    vt[12] = mk(0, 1, 0, 12'h01F, 0, 0, 0, 12'h000, 0,       0, 1, 0, 16'h0,    0, 0, 0, 1, 0, 12'h01F, 16'h0,    1);
    vt[13] = mk(1, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 12'h000, 16'h0,    0);
    vt[14] = mk(0, 1, 0, 12'h01F, 0, 0, 0, 12'h000, 0,       0, 1, 0, 16'h0,    0, 0, 0, 1, 0, 12'h01F, 16'h0,    1);
    vt[15] = mk(0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 1, 16'h3A42, 0, 0, 0, 0, 0, 12'h000, 16'h0,    1);
    vt[16] = mk(0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0,       0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 12'h000, 16'h0,    0);

    for (int i = 0; i < 17; i++) begin
      apply(vt[i]);
      step();
      e = {vt[i].e_cg, vt[i].e_crv, vt[i].e_dg, vt[i].e_drv, vt[i].e_en, vt[i].e_we,
           vt[i].e_busy, vt[i].e_addr, vt[i].e_wd, vt[i].e_crd, vt[i].e_drd};
      m = mk_mask(vt[i].e_en || vt[i].rst, vt[i].e_we || vt[i].rst,
                  vt[i].e_crv || vt[i].e_drv || vt[i].rst);
      chk($sformatf("vec%0d", i), pack_act() & m, e & m);
    end

    // Contention: both read continuously for 12 cycles after a fresh reset.
    idle_inputs(); rst = 1'b1; step();
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 12'h020; dbg_req = 1'b1; dbg_addr = 12'h021;
    gq.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (cpu_gnt && dbg_gnt) gq.push_back(2'b10);
      else if (cpu_gnt)       gq.push_back(2'b00);
      else if (dbg_gnt)       gq.push_back(2'b01);
    end
    idle_inputs();
    chk("contention grant count", 67'(gq.size()), 67'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contention grant%0d", i),
          67'((i < gq.size()) ? gq[i] : 2'b11), 67'(rr_mode ? (i % 2) : 0));
    end
    step(); step(); step();

    // Lock: CPU held for 10 cycles, one debug read must complete.
    dbg_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 12'h030;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h031;
    n_cg = 0; n_drv = 0; d_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (d_seen) dbg_req = 1'b0;
      step();
      if (cpu_gnt) n_cg++;
      if (dbg_gnt) d_seen = 1'b1;
      if (dbg_rvalid) begin
        n_drv++;
        chk("locked dbg rdata", 67'(dbg_rdata), 67'(init_val(12'h031)));
      end
    end
    chk("locked cpu_gnt count", 67'(n_cg), 67'd0);
    chk("locked dbg rvalid count", 67'(n_drv), 67'd1);
    // Lock released while IDLE with cpu_req still held: grant within 2 cycles.
    dbg_lock = 1'b0;
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 4 && !found; i++) begin
      step();
      if (cpu_gnt) begin found = 1'b1; lat = i; end
    end
    chk($sformatf("unlock cpu_gnt latency %0d", lat), 67'(found && lat <= 2), 67'd1);
    idle_inputs();
    step(); step(); step();

    // Randomized traffic, protocol-compliant requesters, occasional lock/reset.
    c_done = 1'b0; d_done = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (c_done || !cpu_req) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
        cpu_wdata = 16'($urandom);
      end
      if (d_done || !dbg_req) begin
        dbg_req   = ($urandom_range(0, 3) != 0);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
        dbg_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 19) == 0) dbg_lock = ~dbg_lock;
      rst = ($urandom_range(0, 199) == 0);
      step();
      c_done = (age == 1) && !m_dbg;
      d_done = (age == 1) && m_dbg;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
